// File: rtl/mem_port_b_arbiter.sv
// Port-B arbiter: VGA pixel fetcher (read-only, priority) vs. aux master (read/write).
// Optional aux starvation guard enabled by defining MEM_PORT_B_ARB_STARVE_GUARD_EN.
module mem_port_b_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 8,
  parameter int WAIT_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_ack,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_rvalid,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_ack,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic                  aux_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic                  mem_we_b,
  output logic [DATA_WIDTH-1:0] mem_data_b,
  input  logic [DATA_WIDTH-1:0] mem_out_b
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE_VGA = 2'd1,
    ISSUE_AUX = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]              tag_q, tag_d;
  logic                    aux_force;

`ifdef MEM_PORT_B_ARB_STARVE_GUARD_EN
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign aux_force = aux_req && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (!aux_req || (state_d == ISSUE_AUX)) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_WAIT, WAIT_W};
  assign aux_force  = 1'b0;
`endif

  // Winner selection; the state only records who was issued, so it never feeds back.
  always_comb begin
    state_d = IDLE;
    addr_d  = addr_q;
    we_d    = 1'b0;
    data_d  = data_q;
    if (aux_req && (aux_force || !vga_req)) begin
      state_d = ISSUE_AUX;
      addr_d  = aux_addr;
      we_d    = aux_we;
      data_d  = aux_wdata;
    end else if (vga_req) begin
      state_d = ISSUE_VGA;
      addr_d  = vga_addr;
    end
  end

  // Owner tag of a read issued this cycle: bit 1 = VGA, bit 0 = aux.
  assign tag_d = {state_q == ISSUE_VGA, (state_q == ISSUE_AUX) && !we_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      tag_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign vga_ack    = (state_q == ISSUE_VGA);
  assign aux_ack    = (state_q == ISSUE_AUX);
  assign mem_addr_b = addr_q;
  assign mem_we_b   = we_q;
  assign mem_data_b = data_q;
  assign vga_rvalid = tag_q[1];
  assign aux_rvalid = tag_q[0];
  assign vga_rdata  = mem_out_b;
  assign aux_rdata  = mem_out_b;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Bench for mem_port_b_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_mem_port_b_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 8;
`ifdef MEM_PORT_B_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } aux_t;

  logic          clk, reset;
  logic          vga_req, vga_ack, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          aux_req, aux_we, aux_ack, aux_rvalid;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
  logic [AW-1:0] mem_addr_b;
  logic          mem_we_b;
  logic [DW-1:0] mem_data_b, mem_out_b;

  mem_port_b_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_data_b(mem_data_b),
    .mem_out_b(mem_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory with one-cycle read latency; bench traffic stays in 0..63.
  logic [DW-1:0] init_img [0:63];
  logic [DW-1:0] ram [0:63];
  logic          load;
  always @(posedge clk) begin
    if (load) ram <= init_img;
    else if (mem_we_b) ram[mem_addr_b[5:0]] <= mem_data_b;
    mem_out_b <= ram[mem_addr_b[5:0]];
  end

  // Reference model state (transaction level)
  logic [DW-1:0] model_mem [0:63];
  logic [AW-1:0] vq [$];
  aux_t          aq [$];
  int            s1_own, s2_own, wcnt;
  logic          s1_we;
  logic [DW-1:0] s1_rdata, s2_rdata, m_data;
  logic [AW-1:0] m_addr;
  bit            rnd_en;
  int            n_chk, n_err;

  logic          obs_vack, obs_aack, obs_vrv, obs_arv, obs_we;
  logic [DW-1:0] obs_vrdata, obs_ardata, obs_mdata;
  logic [AW-1:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    s1_own = 0; s2_own = 0; wcnt = 0; s1_we = 1'b0;
    s1_rdata = '0; s2_rdata = '0; m_data = '0; m_addr = '0;
  endtask

  // One clock cycle: observe and check at the falling edge, then drive and predict.
  task automatic step();
    logic pa_req, pa_we;
    int   w;
    @(negedge clk);
    obs_vack = vga_ack;    obs_aack = aux_ack;
    obs_vrv = vga_rvalid;  obs_arv = aux_rvalid;
    obs_vrdata = vga_rdata; obs_ardata = aux_rdata;
    obs_we = mem_we_b;     obs_addr = mem_addr_b; obs_mdata = mem_data_b;

    check("vga_ack", vga_ack, s1_own == 1);
    check("aux_ack", aux_ack, s1_own == 2);
    check("mem_we_b", mem_we_b, s1_we);
    check("mem_addr_b", mem_addr_b, m_addr);
    check("mem_data_b", mem_data_b, m_data);
    check("vga_rvalid", vga_rvalid, s2_own == 1);
    check("aux_rvalid", aux_rvalid, s2_own == 2);
    if (s2_own == 1) check("vga_rdata", vga_rdata, s2_rdata);
    if (s2_own == 2) check("aux_rdata", aux_rdata, s2_rdata);

    if (s1_own == 1 && vq.size() > 0) void'(vq.pop_front());
    if (s1_own == 2 && aq.size() > 0) void'(aq.pop_front());
    if (rnd_en) begin
      if (vq.size() < 3 && $urandom_range(0, 2) == 0) vq.push_back(AW'($urandom_range(0, 63)));
      if (aq.size() < 2 && $urandom_range(0, 3) == 0)
        aq.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom_range(0, 63)),
                       wdata: DW'($urandom)});
    end

    pa_req = aux_req; pa_we = aux_we;
    vga_req = (vq.size() > 0);
    if (vga_req) vga_addr = vq[0];
    aux_req = (aq.size() > 0);
    if (aux_req) begin
      aux_we = aq[0].we; aux_addr = aq[0].addr; aux_wdata = aq[0].wdata;
    end
    if (!reset && pa_req && !obs_aack)
      assert (aux_req && aux_we == pa_we) else $error("aux request changed before its ack");

    w = 0;
    if (aux_req && (!vga_req || (GUARD && wcnt == MAXW))) w = 2;
    else if (vga_req) w = 1;
    if (GUARD) begin
      if (!aux_req || w == 2) wcnt = 0;
      else if (wcnt < MAXW) wcnt++;
    end

    s2_own   = (s1_own == 1) ? 1 : ((s1_own == 2 && !s1_we) ? 2 : 0);
    s2_rdata = s1_rdata;
    s1_own   = w;
    s1_we    = 1'b0;
    if (w == 1) begin
      m_addr   = vga_addr;
      s1_rdata = model_mem[vga_addr[5:0]];
    end else if (w == 2) begin
      m_addr = aux_addr;
      m_data = aux_wdata;
      s1_we  = aux_we;
      s1_rdata = model_mem[aux_addr[5:0]];
      if (aux_we) model_mem[aux_addr[5:0]] = aux_wdata;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    vq.delete(); aq.delete();
    vga_req = 1'b0; aux_req = 1'b0;
    model_clear();
    #1;
    check("rst_vga_ack", vga_ack, 0);
    check("rst_aux_ack", aux_ack, 0);
    check("rst_vga_rvalid", vga_rvalid, 0);
    check("rst_aux_rvalid", aux_rvalid, 0);
    check("rst_mem_we", mem_we_b, 0);
    check("rst_mem_addr", mem_addr_b, 0);
    check("rst_mem_data", mem_data_b, 0);
    repeat (n) begin
      step();
      check("rst_hold_vrv", obs_vrv, 0);
      check("rst_hold_addr", obs_addr, 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    int vbefore, vtotal;
    bit aux_seen;
    logic [DW-1:0] exp10;
    n_chk = 0; n_err = 0; rnd_en = 1'b0;
    vga_req = 1'b0; vga_addr = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
    for (int i = 0; i < 64; i++) init_img[i] = DW'(i * 16'h0101) ^ 16'h5A5A;
    init_img[16] = 16'hBEEF;
    for (int i = 0; i < 64; i++) model_mem[i] = init_img[i];
    model_clear();
    reset = 1'b0; load = 1'b1;
    #2;
    do_reset(3);
    load = 1'b0;
    step();

    // Single VGA read of a preloaded word
    vq.push_back(16'h0010);
    step();
    step(); check("t1_vack", obs_vack, 1); check("t1_aack", obs_aack, 0);
    step(); check("t1_vrv", obs_vrv, 1); check("t1_vrdata", obs_vrdata, 16'hBEEF);
    check("t1_arv", obs_arv, 0);
    step(); check("t1_vrv_once", obs_vrv, 0);

    // Aux write then read-back of the same word
    aq.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'h1234});
    aq.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000});
    step();
    step(); check("t2_we", obs_we, 1); check("t2_addr", obs_addr, 16'h0020);
    check("t2_wdata", obs_mdata, 16'h1234); check("t2_aack_w", obs_aack, 1);
    step(); check("t2_we_once", obs_we, 0); check("t2_aack_r", obs_aack, 1);
    check("t2_no_rv_for_write", obs_arv, 0);
    step(); check("t2_arv", obs_arv, 1); check("t2_ardata", obs_ardata, 16'h1234);
    step(); check("t2_arv_once", obs_arv, 0);

    // Simultaneous VGA and aux reads
    vq.push_back(16'h0010);
    aq.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000});
    step();
    step(); check("t3_vack", obs_vack, 1); check("t3_aack_late", obs_aack, 0);
    step(); check("t3_aack", obs_aack, 1); check("t3_vrv", obs_vrv, 1);
    check("t3_vrdata", obs_vrdata, 16'hBEEF); check("t3_arv_early", obs_arv, 0);
    step(); check("t3_arv", obs_arv, 1); check("t3_ardata", obs_ardata, 16'h1234);
    check("t3_vrv_once", obs_vrv, 0);
    repeat (3) step();

    // VGA streaming 20 reads while aux waits
    for (int i = 0; i < 20; i++) vq.push_back(AW'(i));
    aq.push_back('{we: 1'b0, addr: 16'h0030, wdata: 16'h0000});
    vbefore = 0; vtotal = 0; aux_seen = 1'b0;
    repeat (30) begin
      step();
      if (obs_aack) aux_seen = 1'b1;
      if (obs_vack) begin
        vtotal++;
        if (!aux_seen) vbefore++;
      end
    end
    check("t4_aux_acked", aux_seen, 1);
    check("t4_vacks_before_aux", vbefore, GUARD ? MAXW : 20);
    check("t4_vacks_total", vtotal, 20);

    // Random mixed traffic
    rnd_en = 1'b1;
    repeat (400) step();
    rnd_en = 1'b0;
    repeat (10) step();

    // Reset while a VGA read is in flight
    vq.push_back(16'h0007);
    step();
    step(); check("t5_vack", obs_vack, 1);
    do_reset(3);
    step(); check("t5_no_late_rv", obs_vrv, 0);
    exp10 = model_mem[16];
    vq.push_back(16'h0010);
    step();
    step(); check("t5_post_vack", obs_vack, 1);
    step(); check("t5_post_vrv", obs_vrv, 1); check("t5_post_vrdata", obs_vrdata, exp10);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_b_arbiter.md
Name: mem_port_b_arbiter

Overview:
Shares the data memory's second port (port B) between two requesters: the VGA pixel fetcher (read-only, high priority) and an auxiliary master (read/write; SNES button store, debug loader). It sits between the Memory port-B pins and the requesters inside Datapath, replacing the direct VGA-to-addr_b connection. Arbitration and memory-side outputs are registered, and at most one port-B access is issued per cycle.

Parameters:
ADDR_WIDTH, 16, width of memory address
DATA_WIDTH, 16, width of memory word
MAX_WAIT, 8, aux wait cycles before forced aux grant (optional feature only)
WAIT_W, 4, width of aux wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
vga_req  input  1  VGA read request; hold with vga_addr stable until vga_ack
vga_addr  input  ADDR_WIDTH  VGA read address
vga_ack  output  1  one-cycle pulse: VGA request issued to memory this cycle
vga_rdata  output  DATA_WIDTH  read data, valid when vga_rvalid
vga_rvalid  output  1  one-cycle pulse, VGA read data valid
aux_req  input  1  aux request; hold with aux_we/aux_addr/aux_wdata stable until aux_ack
aux_we  input  1  1 = write, 0 = read
aux_addr  input  ADDR_WIDTH  aux address
aux_wdata  input  DATA_WIDTH  aux write data
aux_ack  output  1  one-cycle pulse: aux request issued to memory this cycle
aux_rdata  output  DATA_WIDTH  read data, valid when aux_rvalid
aux_rvalid  output  1  one-cycle pulse, aux read data valid (reads only)
mem_addr_b  output  ADDR_WIDTH  to Memory addr_b
mem_we_b  output  1  to Memory w_en_b
mem_data_b  output  DATA_WIDTH  to Memory data_b
mem_out_b  input  DATA_WIDTH  from Memory port-B read output; synchronous, one-cycle latency

Behaviour:
- Reset (async, active-high): mem_addr_b=0, mem_we_b=0, mem_data_b=0, all ack/rvalid=0, the issue pipeline is cleared, and the wait counter is 0. In-flight reads are dropped and produce no rvalid after reset.
- Cycle N: requests are sampled and a winner is chosen.
- Edge ending N: the winner's address, write enable and write data are registered onto the mem_* outputs; in cycle N+1, winner ack=1.
- Memory samples at the edge ending N+1. For a read, mem_out_b is valid in N+2, so rdata=mem_out_b combinationally and rvalid=1 in N+2. Read latency from ack is 1 cycle; from first req sample, 2 cycles.
- Writes produce no rvalid.
- Default priority: VGA beats aux.
- Requester holding req in the ack cycle: this is treated as a new request (back-to-back, one access per cycle).
  - A requester must drop req in the ack cycle if it has no further request.
  - Full throughput: VGA streaming continuously acks every cycle.
- Idle (no winner): mem_we_b=0 next cycle; mem_addr_b and mem_data_b hold their last values.
- mem_we_b is asserted for exactly one cycle per aux write.
- A 2-bit owner/read tag pipeline tracks the owner of each issued read, one stage per cycle, and routes rvalid to exactly one requester. rdata on the non-owning side is don't-care but is driven from mem_out_b.
- Simultaneous VGA read and aux write to the same address: VGA is issued first and reads the old data; aux issues in a later cycle.
- aux_req with aux_we toggling mid-request violates the protocol; behaviour is undefined and a bench assertion flags it.
- States: IDLE (no issue last cycle), ISSUE_VGA, ISSUE_AUX. The next state depends only on the current requests and the wait counter, not on the current state.

Optional Feature:
Macro MEM_PORT_B_ARB_STARVE_GUARD_EN.
- Defined:
  - The wait counter increments each cycle aux_req=1 and aux is not the winner, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, aux beats VGA in that arbitration.
  - The counter clears when aux wins, or when aux_req=0.
- Undefined: the counter is not built, and strict VGA priority applies. A continuous vga_req starves aux indefinitely.

Test Plan:
- Preload mem[0x0010]=0xBEEF; vga_req with addr 0x0010 for one cycle -> vga_ack in N+1, vga_rvalid with vga_rdata=0xBEEF in N+2, aux_rvalid stays 0.
- aux write 0x0020<-0x1234, then aux read 0x0020 -> one mem_we_b pulse with mem_addr_b=0x0020, then aux_rdata=0x1234 two cycles after the read req, no rvalid for the write.
- vga_req and aux_req asserted together for one cycle each -> vga_ack in cycle 1, aux_ack in cycle 2, both rvalids routed correctly.
- vga_req held 20 cycles on addresses 0..19 with aux_req held:
  - With the macro (MAX_WAIT=8): aux_ack appears after 8 VGA acks, then VGA resumes.
  - Without the macro: aux_ack only after vga_req drops.
- Assert reset one cycle after a VGA read is acked -> no vga_rvalid, all outputs 0 until reset deasserts, and the first post-reset request follows normal latency.
